enable_sequencer: RTL

ENABLE_SEQUENCER -- requirements
Module: enable_sequencer

---
 rtl/enable_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/enable_sequencer.sv
// enable_sequencer: generates repeated enable bursts (ON for on_len cycles,
// OFF for off_len cycles) for a downstream synchronous-signal stage.
// Ports: clk, reset (async, active-high), start, abort, on_len, off_len,
//        repeat_cnt in; enable, busy, done, burst_idx out (all registered).
// Build option: ENABLE_SEQ_CONTINUOUS_EN makes repeat_cnt=0 run endless
// bursts; without it repeat_cnt=0 only pulses done.
module enable_sequencer #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] on_len,
    input  logic [CNT_W-1:0] off_len,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] burst_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] on_q;
    logic [CNT_W-1:0] off_q;
    logic [REP_W-1:0] rep_q;

    logic phase_end;
    logic last_burst;
    logic start_acc;
    logic start_go;
    logic zero_rep;
    logic enable_d;
    logic busy_d;
    logic done_d;

    // ON lasts max(len,1) cycles: counter loads len-1, phase ends at 0.
    function automatic logic [CNT_W-1:0] on_reload(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    assign phase_end = (cnt == '0);
    assign start_acc = (state == IDLE) && start && !abort;

`ifdef ENABLE_SEQ_CONTINUOUS_EN
    // rep_q=0 means endless: no burst is ever the last one.
    assign last_burst = (rep_q != '0) && (burst_idx == rep_q - REP_W'(1));
    assign zero_rep   = 1'b0;
    assign start_go   = start_acc;
`else
    assign last_burst = (burst_idx == rep_q - REP_W'(1));
    assign zero_rep   = start_acc && (repeat_cnt == '0);
    assign start_go   = start_acc && (repeat_cnt != '0);
`endif

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            enable <= enable_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start_go) state_d = ON;
            end
            ON: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (phase_end) begin
                    if (last_burst)          state_d = IDLE;
                    else if (off_q != '0)    state_d = OFF;
                    else                     state_d = ON;
                end
            end
            OFF: begin
                if (abort)          state_d = IDLE;
                else if (phase_end) state_d = ON;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic (values for the next cycle)
    always_comb begin
        enable_d = (state_d == ON);
        busy_d   = (state_d != IDLE);
        done_d   = zero_rep;
        if ((state == ON) && !abort && phase_end && last_burst)
            done_d = 1'b1;
    end

    // Counter, burst index and latched configuration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            on_q      <= '0;
            off_q     <= '0;
            rep_q     <= '0;
            burst_idx <= '0;
        end else if (start_acc) begin
            on_q      <= on_len;
            off_q     <= off_len;
            rep_q     <= repeat_cnt;
            burst_idx <= '0;
            cnt       <= on_reload(on_len);
        end else if (state != IDLE && state_d != IDLE) begin
            if (phase_end && state_d == ON) begin
                // new burst: either after OFF or back-to-back ON
                cnt       <= on_reload(on_q);
                burst_idx <= burst_idx + REP_W'(1);
            end else if (phase_end && state_d == OFF) begin
                cnt <= off_q - CNT_W'(1);
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
